// File: rtl/scc_dbg_pkg.sv
// Shared definitions for the SCC run/dump sequencer: FSM encodings, status codes, dump defaults.
package scc_dbg_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RST       = 3'd1;
    localparam logic [2:0] RUN       = 3'd2;
    localparam logic [2:0] DUMP_RD   = 3'd3;
    localparam logic [2:0] DUMP_WAIT = 3'd4;
    localparam logic [2:0] DUMP_OUT  = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_HALT = 2'b01;
    localparam logic [1:0] ST_TMO  = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    localparam logic [31:0] DUMP_BASE_DEF = 32'h0000_0400;

endpackage

// File: rtl/scc_dump_seq.sv
// Memory-window dump sequencer: reads DUMP_WORDS words through the debug port and
// streams them out as address/data beats over valid/ready.
module scc_dump_seq
    import scc_dbg_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] DUMP_BASE  = ADDR_W'(DUMP_BASE_DEF),
    parameter int unsigned       DUMP_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start,
    output logic              dump_finish,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last
);

    localparam int unsigned      IDX_W    = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_WORDS - 1);

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] rd_addr, addr_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    // Wraps modulo 2^ADDR_W by construction.
    assign rd_addr = DUMP_BASE + (ADDR_W'(idx_q) << 2);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dump_finish = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = DUMP_RD;
                    idx_d   = '0;
                end
            end
            DUMP_RD:   state_d = DUMP_WAIT;
            DUMP_WAIT: state_d = DUMP_OUT;
            DUMP_OUT: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = IDLE;
                        idx_d       = '0;
                        dump_finish = 1'b1;
                    end else begin
                        state_d = DUMP_RD;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // Read data is valid in the cycle after the strobe.
            if (state_q == DUMP_WAIT) begin
                addr_q <= rd_addr;
                data_q <= mem_rd_data;
                last_q <= (idx_q == LAST_IDX);
            end
        end
    end

    assign mem_rd_en  = (state_q == DUMP_RD);
    assign mem_addr   = mem_rd_en ? rd_addr : '0;
    assign dump_valid = (state_q == DUMP_OUT);
    assign dump_addr  = addr_q;
    assign dump_data  = data_q;
    assign dump_last  = dump_valid & last_q;

endmodule

// File: rtl/scc_run_ctrl.sv
// Run/dump sequencer around the SCC core: reset hold, cycle-counted run with
// halt/error/timeout exit, then a data-memory window dump.
module scc_run_ctrl
    import scc_dbg_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       CNT_W      = 32,
    parameter int unsigned       RST_CYCLES = 3,
    parameter int unsigned       MAX_CYCLES = 100000,
    parameter logic [ADDR_W-1:0] DUMP_BASE  = ADDR_W'(DUMP_BASE_DEF),
    parameter int unsigned       DUMP_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              core_rst,
    output logic              core_clk_en,
    input  logic              halt_f,
    input  logic [1:0]        err_bits,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [1:0]        status,
    output logic              done
);

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(MAX_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       status_q, status_d;
    logic             run_exit;
    logic [1:0]       exit_status;
    logic             dump_start;
    logic             dump_finish;

    // Error outranks halt, halt outranks timeout.
    always_comb begin
        run_exit    = 1'b1;
        exit_status = ST_RUN;
        if (err_bits != 2'b00) begin
            exit_status = ST_ERR;
        end else if (halt_f) begin
            exit_status = ST_HALT;
        end else if (cnt_q == TMO_CNT) begin
            exit_status = ST_TMO;
        end else begin
            run_exit = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cnt_d     = cnt_q;
        status_d  = status_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RST;
                    rst_cnt_d = 32'(RST_CYCLES - 1);
                    cnt_d     = '0;
                    status_d  = ST_RUN;
                end
            end
            RST: begin
                if (rst_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (run_exit) begin
                    state_d  = DUMP_RD;
                    status_d = exit_status;
                end
            end
            // DUMP_RD stands for the whole dump phase owned by scc_dump_seq.
            DUMP_RD: begin
                if (dump_finish) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rst_cnt_q <= '0;
            cnt_q     <= '0;
            status_q  <= ST_RUN;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cnt_q     <= cnt_d;
            status_q  <= status_d;
        end
    end

    assign dump_start  = (state_q == RUN) && run_exit;
    assign core_rst    = (state_q == IDLE) || (state_q == RST);
    assign core_clk_en = (state_q == RUN);
    assign cycle_count = cnt_q;
    assign status      = status_q;
    assign done        = (state_q == DONE);

    scc_dump_seq #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DUMP_BASE  (DUMP_BASE),
        .DUMP_WORDS (DUMP_WORDS)
    ) u_dump_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .dump_start  (dump_start),
        .dump_finish (dump_finish),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .dump_last   (dump_last)
    );

endmodule

// File: tb/tb_scc_run_ctrl.sv
// Bench for scc_run_ctrl: stub core and memory, scoreboard of dump beats, run-level checks.
module tb_scc_run_ctrl;

    localparam int unsigned MAX_C = 60;
    localparam int unsigned RST_C = 3;
    localparam int unsigned WORDS = 16;
    localparam logic [31:0] BASE  = 32'h0000_0400;

    logic        clk, rst_n, start;
    logic        core_rst, core_clk_en, halt_f;
    logic [1:0]  err_bits;
    logic        mem_rd_en;
    logic [31:0] mem_addr, mem_rd_data;
    logic        dump_valid, dump_ready, dump_last;
    logic [31:0] dump_addr, dump_data, cycle_count;
    logic [1:0]  status;
    logic        done;

    scc_run_ctrl #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .CNT_W      (32),
        .RST_CYCLES (RST_C),
        .MAX_CYCLES (MAX_C),
        .DUMP_BASE  (BASE),
        .DUMP_WORDS (WORDS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .core_rst    (core_rst),
        .core_clk_en (core_clk_en),
        .halt_f      (halt_f),
        .err_bits    (err_bits),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .dump_last   (dump_last),
        .cycle_count (cycle_count),
        .status      (status),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Stub core: halt/error rise on the Nth enabled cycle after its reset.
    int          halt_at = 0;
    int          err_at  = 0;
    logic [1:0]  err_val = 2'b10;
    int          en_cnt  = 0;
    logic [31:0] mem_seed = 32'h0;

    always @(posedge clk) begin
        if (core_rst) en_cnt <= 0;
        else if (core_clk_en) en_cnt <= en_cnt + 1;
    end
    assign halt_f   = core_clk_en && (halt_at != 0) && (en_cnt >= halt_at - 1);
    assign err_bits = (core_clk_en && (err_at != 0) && (en_cnt >= err_at - 1)) ? err_val : 2'b00;

    // Memory stub: word at byte address a holds (a/4) ^ seed, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= (mem_addr / 4) ^ mem_seed;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t exp_q[$];

    int    en_total    = 0;
    int    beat_total  = 0;
    int    stall_total = 0;
    int    beat_base   = 0;
    int    ready_mode  = 0;
    int    stall_left  = 0;
    logic  prev_stall  = 1'b0;
    beat_t held;

    // Downstream ready driver.
    initial begin
        dump_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: dump_ready = 1'b1;
                1: begin
                    if (dump_valid && (beat_total - beat_base == 2) && stall_left > 0) begin
                        dump_ready = 1'b0;
                        stall_left--;
                    end else begin
                        dump_ready = 1'b1;
                    end
                end
                default: dump_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: scoreboard pop on every accepted beat, stability under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (core_clk_en) en_total++;
            if (prev_stall) begin
                check("stall_valid", 64'(dump_valid), 64'd1);
                check("stall_addr", 64'(dump_addr), 64'(held.addr));
                check("stall_data", 64'(dump_data), 64'(held.data));
                check("stall_last", 64'(dump_last), 64'(held.last));
            end
            if (dump_valid && !dump_ready && (beat_total - beat_base == 2)) stall_total++;
            if (dump_valid && dump_ready) begin
                check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_addr", 64'(dump_addr), 64'(e.addr));
                    check("beat_data", 64'(dump_data), 64'(e.data));
                    check("beat_last", 64'(dump_last), 64'(e.last));
                end
                beat_total++;
            end
            prev_stall = dump_valid && !dump_ready;
            held.addr  = dump_addr;
            held.data  = dump_data;
            held.last  = dump_last;
        end
    end

    // Reference: the run ends on the first enabled cycle where any exit cause holds.
    function automatic void model(input int h, input int e, output int n, output logic [1:0] st);
        n  = MAX_C;
        st = 2'b10;
        if (h != 0 && h <= n) begin
            n  = h;
            st = 2'b01;
        end
        if (e != 0 && e <= n) begin
            n  = e;
            st = 2'b11;
        end
    endfunction

    task automatic do_run(input int h, input int e, input logic [1:0] ev, input logic [31:0] seed,
                          input int mode, input int restart_at, input int abort_beat);
        int         n;
        logic [1:0] st;
        int         en_base, stall_base, rst_cyc, guard;
        logic       reached;
        model(h, e, n, st);
        halt_at    = h;
        err_at     = e;
        err_val    = ev;
        mem_seed   = seed;
        ready_mode = mode;
        stall_left = 7;
        for (int i = 0; i < int'(WORDS); i++) begin
            beat_t b;
            b.addr = BASE + 32'(4 * i);
            b.data = (b.addr / 4) ^ seed;
            b.last = (i == int'(WORDS) - 1);
            exp_q.push_back(b);
        end
        @(negedge clk);
        beat_base  = beat_total;
        en_base    = en_total;
        stall_base = stall_total;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_cyc = 0;
        while (core_rst && !core_clk_en && rst_cyc < 20) begin
            rst_cyc++;
            @(negedge clk);
        end
        check("rst_cycles", 64'(rst_cyc), 64'(RST_C));
        check("clk_en_after_rst", 64'(core_clk_en), 64'd1);
        if (restart_at > 0) begin
            repeat (restart_at) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (abort_beat > 0) begin
            reached = 1'b0;
            guard   = 0;
            while (!reached && guard < 3000) begin
                @(posedge clk);
                #2;
                guard++;
                reached = dump_valid && (beat_total - beat_base == abort_beat);
            end
            check("abort_reached", 64'(reached), 64'd1);
            rst_n = 1'b0;
            #1;
            check("abort_valid", 64'(dump_valid), 64'd0);
            check("abort_core_rst", 64'(core_rst), 64'd1);
            check("abort_clk_en", 64'(core_clk_en), 64'd0);
            check("abort_done", 64'(done), 64'd0);
            check("abort_count", 64'(cycle_count), 64'd0);
            check("abort_status", 64'(status), 64'd0);
            check("abort_dump_addr", 64'(dump_addr), 64'd0);
            exp_q.delete();
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            guard = 0;
            while (!done && guard < 3000) begin
                @(negedge clk);
                guard++;
            end
            check("done", 64'(done), 64'd1);
            check("status", 64'(status), 64'(st));
            check("cycle_count", 64'(cycle_count), 64'(n));
            check("enabled_cycles", 64'(en_total - en_base), 64'(n));
            check("beat_count", 64'(beat_total - beat_base), 64'(WORDS));
            check("beats_left", 64'(exp_q.size()), 64'd0);
            check("done_core_rst", 64'(core_rst), 64'd0);
            check("done_clk_en", 64'(core_clk_en), 64'd0);
            if (mode == 1) check("stall_len", 64'(stall_total - stall_base), 64'd7);
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_clk_en", 64'(core_clk_en), 64'd0);
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_dump_valid", 64'(dump_valid), 64'd0);
        check("rst_dump_last", 64'(dump_last), 64'd0);
        check("rst_dump_data", 64'(dump_data), 64'd0);
        check("rst_cycle_count", 64'(cycle_count), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_run(50, 0, 2'b10, 32'h0, 0, 0, 0);           // plain halt, data 0x100..0x10F
        do_run(50, 0, 2'b10, 32'h0, 1, 0, 0);           // 7-cycle stall on beat 3
        do_run(0, 0, 2'b10, 32'h0, 0, 0, 0);            // timeout
        do_run(12, 12, 2'b10, 32'h0, 0, 0, 0);          // error and halt together
        do_run(30, 0, 2'b10, 32'h0, 0, 0, 4);           // async reset on beat 5
        do_run(25, 0, 2'b10, 32'h5a5a_0000, 0, 10, 0);  // start ignored in RUN
        do_run(7, 0, 2'b10, 32'h0, 0, 0, 0);            // fresh run from DONE
        do_run(1, 0, 2'b10, 32'hffff_ffff, 2, 0, 0);    // exit on first cycle
        do_run(MAX_C, 0, 2'b10, 32'h0, 0, 0, 0);        // halt ties timeout
        for (int r = 0; r < 6; r++) begin
            int         h, e, m;
            logic [1:0] ev;
            h  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 70));
            e  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 70)) : 0;
            ev = 2'($urandom_range(1, 3));
            m  = int'($urandom_range(0, 2));
            do_run(h, e, ev, $urandom, m, 0, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
